// File: rtl/bcd_scan_display.sv
// Time-multiplexed 7-segment driver for a latched vector of BCD digits.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_scan_display #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    latch,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [BCD_W-1:0]      shadow_q, shadow_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            cur_digit;
  logic                  lz_blank;

  // Codes above 9 come from a misloaded counter and are shown as a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Prescaler and digit index rotation.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    idx_d     = idx_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    shadow_d = latch ? bcd_in : shadow_q;
  end

  // Select the currently scanned digit from the shadow register.
  always_comb begin
    cur_digit = 4'h0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = shadow_q[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i blanks when it and every higher digit are zero; digit 0 always shows.
  logic hi_zero;
  always_comb begin
    lz_blank = 1'b0;
    hi_zero  = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      hi_zero = hi_zero & (shadow_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) lz_blank = hi_zero;
    end
  end
`else
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  // Output stage driven from pre-edge idx and shadow.
  always_comb begin
    seg_d = 7'h00;
    an_d  = '0;
    if (!blank) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        an_d[i] = (idx_q == IDX_W'(i));
      end
      seg_d = lz_blank ? 7'h00 : decode(cur_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q  <= '0;
      div_cnt_q <= '0;
      idx_q     <= '0;
      seg_q     <= 7'h00;
      an_q      <= '0;
    end else begin
      shadow_q  <= shadow_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed vector table plus randomized
// traffic compared against a cycle-count based reference model.
module tb_bcd_scan_display;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZH = 7'h00;
`else
  localparam logic [6:0] ZH = 7'h3F;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          latch;
  logic          blank;
  logic [15:0]   bcd_in;
  logic [6:0]    seg;
  logic [ND-1:0] an;

  int checks = 0;
  int passed = 0;

  // Reference state: edges since reset release and the captured digits.
  int unsigned m_ticks  = 0;
  logic [15:0] m_shadow = 16'h0;

  typedef struct {
    logic        rst;
    logic        lat;
    logic        blk;
    logic [15:0] bcd;
    int          n;
    logic [6:0]  seg;
    logic [3:0]  an;
  } vec_t;

  vec_t tab[$];

  bcd_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk    (clk),
    .reset  (reset),
    .bcd_in (bcd_in),
    .latch  (latch),
    .blank  (blank),
    .seg    (seg),
    .an     (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [15:0] sh, input int unsigned d);
    logic [3:0] v;
    v = 4'((sh >> (4 * d)) & 16'h000F);
`ifdef LEADING_ZERO_BLANK_EN
    if (d != 0 && (sh >> (4 * d)) == 16'h0) return 7'h00;
`endif
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock edge: predict from pre-edge state, advance model, compare.
  task automatic tick(input bit use_tab, input logic [6:0] t_seg, input logic [3:0] t_an);
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    int unsigned idx;
    logic        r, l;
    logic [15:0] b;
    r = reset; l = latch; b = bcd_in;
    e_seg = 7'h00;
    e_an  = 4'h0;
    if (r && !blank) begin
      idx   = (m_ticks / SD) % ND;
      e_an  = 4'(1 << idx);
      e_seg = ref_seg(m_shadow, idx);
    end
    @(posedge clk);
    #1;
    if (!r) begin
      m_ticks  = 0;
      m_shadow = 16'h0;
    end else begin
      m_ticks++;
      if (l) m_shadow = b;
    end
    check("model_seg", 16'(seg), 16'(e_seg));
    check("model_an", 16'(an), 16'(e_an));
    if (use_tab) begin
      check("table_seg", 16'(seg), 16'(t_seg));
      check("table_an", 16'(an), 16'(t_an));
    end
  endtask

  task automatic add(input logic r, input logic l, input logic bk, input logic [15:0] d,
                     input int n, input logic [6:0] s, input logic [3:0] a);
    vec_t v;
    v.rst = r; v.lat = l; v.blk = bk; v.bcd = d; v.n = n; v.seg = s; v.an = a;
    tab.push_back(v);
  endtask

  initial begin
    reset  = 1'b0;
    latch  = 1'b0;
    blank  = 1'b0;
    bcd_in = 16'h0;

    // Reset hold, release and full scan rotation with wrap.
    add(0, 0, 0, 16'h0000, 3, 7'h00, 4'b0000);
    add(1, 0, 0, 16'h0000, 4, 7'h3F, 4'b0001);
    add(1, 0, 0, 16'h0000, 4, ZH,    4'b0010);
    add(1, 0, 0, 16'h0000, 4, ZH,    4'b0100);
    add(1, 0, 0, 16'h0000, 4, ZH,    4'b1000);
    add(1, 0, 0, 16'h0000, 1, 7'h3F, 4'b0001);
    // Capture 1234, then ignore bcd_in changes without latch.
    add(1, 1, 0, 16'h1234, 1, 7'h3F, 4'b0001);
    add(1, 0, 0, 16'h9999, 2, 7'h66, 4'b0001);
    add(1, 0, 0, 16'h9999, 4, 7'h4F, 4'b0010);
    add(1, 0, 0, 16'h9999, 4, 7'h5B, 4'b0100);
    add(1, 0, 0, 16'h9999, 4, 7'h06, 4'b1000);
    add(1, 0, 0, 16'h9999, 4, 7'h66, 4'b0001);
    // Out-of-range digit shows a dash.
    add(1, 1, 0, 16'h0A05, 1, 7'h4F, 4'b0010);
    add(1, 0, 0, 16'h0A05, 3, 7'h3F, 4'b0010);
    add(1, 0, 0, 16'h0A05, 4, 7'h40, 4'b0100);
    add(1, 0, 0, 16'h0A05, 4, ZH,    4'b1000);
    add(1, 0, 0, 16'h0A05, 4, 7'h6D, 4'b0001);
    // Blank mid-frame; scanning keeps advancing underneath.
    add(1, 0, 0, 16'h0A05, 1, 7'h3F, 4'b0010);
    add(1, 0, 1, 16'h0A05, 6, 7'h00, 4'b0000);
    add(1, 0, 0, 16'h0A05, 1, 7'h40, 4'b0100);
    add(1, 0, 0, 16'h0A05, 4, ZH,    4'b1000);
    // Latch on the same edge as the index wrap.
    add(1, 0, 0, 16'h0A05, 4, 7'h6D, 4'b0001);
    add(1, 0, 0, 16'h0A05, 4, 7'h3F, 4'b0010);
    add(1, 0, 0, 16'h0A05, 4, 7'h40, 4'b0100);
    add(1, 0, 0, 16'h0A05, 3, ZH,    4'b1000);
    add(1, 1, 0, 16'h3105, 1, ZH,    4'b1000);
    add(1, 0, 0, 16'h3105, 4, 7'h6D, 4'b0001);
    add(1, 0, 0, 16'h3105, 4, 7'h3F, 4'b0010);
    add(1, 0, 0, 16'h3105, 2, 7'h06, 4'b0100);
    // Reset mid-slot clears shadow and restarts at digit 0.
    add(0, 0, 0, 16'h3105, 1, 7'h00, 4'b0000);
    add(1, 0, 0, 16'h3105, 1, 7'h3F, 4'b0001);
    add(1, 0, 0, 16'h3105, 3, 7'h3F, 4'b0001);
    add(1, 0, 0, 16'h3105, 4, ZH,    4'b0010);
    // Leading-zero behaviour on 0070; digit 0 always shows.
    add(1, 1, 0, 16'h0070, 1, ZH,    4'b0100);
    add(1, 0, 0, 16'h0070, 3, ZH,    4'b0100);
    add(1, 0, 0, 16'h0070, 4, ZH,    4'b1000);
    add(1, 0, 0, 16'h0070, 4, 7'h3F, 4'b0001);
    add(1, 0, 0, 16'h0070, 4, 7'h07, 4'b0010);

    foreach (tab[k]) begin
      reset  = tab[k].rst;
      latch  = tab[k].lat;
      blank  = tab[k].blk;
      bcd_in = tab[k].bcd;
      for (int c = 0; c < tab[k].n; c++) tick(1'b1, tab[k].seg, tab[k].an);
    end

    // Latch held high tracks bcd_in every cycle.
    latch = 1'b1;
    for (int c = 0; c < 24; c++) begin
      bcd_in = 16'($urandom);
      tick(1'b0, 7'h00, 4'h0);
    end
    latch = 1'b0;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      reset  = ($urandom_range(0, 59) != 0);
      latch  = ($urandom_range(0, 3) == 0);
      blank  = ($urandom_range(0, 9) == 0);
      bcd_in = (($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom) & 16'h0F0F);
      tick(1'b0, 7'h00, 4'h0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
